// File: rtl/overture_io_pkg.sv
// rtl/overture_io_pkg.sv - shared types and constants for the overture CPU output path
//
// Purpose: byte type, default FIFO depth and statistics counter widths
// shared by overture_out_fifo and overture_fifo_ram.
// Ports: none (package).

package overture_io_pkg;

    typedef logic [7:0] byte_t;

    localparam int DEFAULT_DEPTH = 16;
    localparam int BYTE_COUNT_W  = 16;
    localparam int DROP_COUNT_W  = 8;

endpackage

// File: rtl/overture_fifo_ram.sv
// rtl/overture_fifo_ram.sv - FIFO storage array, one write port and one read port
//
// Purpose: byte storage for overture_out_fifo. The storage has no reset.
// Ports:
//   clk      - clock
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write byte
//   rd_addr  - read address; the caller drives it from a register
//   rd_data  - byte stored at rd_addr

module overture_fifo_ram
    import overture_io_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    byte_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read address is a flop in the caller and the array is flops, so the
    // output has no path from this cycle's write data.
    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/overture_out_fifo.sv
// rtl/overture_out_fifo.sv - CPU output byte FIFO with valid/ready drain side
//
// Purpose: buffers bytes strobed out by the CPU and presents them in order on
// a valid/ready interface. Drops bytes when full and flags it stickily.
// Optional statistics ports when OVERTURE_OUT_FIFO_STATS_EN is defined.
// Ports:
//   clk, rst                  - clock, asynchronous active-low reset
//   arch_output_enable/value  - CPU output strobe and byte
//   flush                     - synchronous discard of all buffered bytes
//   out_valid/out_ready/data  - drain interface, head of FIFO
//   level                     - occupancy 0..DEPTH
//   overflow                  - sticky drop flag
//   byte_count, drop_count    - accepted pushes (wrapping) / drops (saturating),
//                               present only with OVERTURE_OUT_FIFO_STATS_EN

module overture_out_fifo
    import overture_io_pkg::*;
#(
    parameter int    UUID  = 0,
    parameter string NAME  = "",
    parameter int    DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arch_output_enable,
    input  logic [7:0]             arch_output_value,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
`ifdef OVERTURE_OUT_FIFO_STATS_EN
    ,
    output logic [BYTE_COUNT_W-1:0] byte_count,
    output logic [DROP_COUNT_W-1:0] drop_count
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;

    logic full, empty, pop, push, drop, wr_en;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign pop   = !empty && out_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    assign push  = arch_output_enable && (!full || pop);
    assign drop  = arch_output_enable && full && !pop;
    assign wr_en = push && !flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            // Pointers are AW bits wide and wrap naturally at DEPTH.
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      level_d = level_q + LVL_W'(1);
            else if (pop && !push) level_d = level_q - LVL_W'(1);
            if (drop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    overture_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (arch_output_value),
        .rd_addr (rd_ptr_q),
        .rd_data (out_data)
    );

    assign out_valid = !empty;
    assign level     = level_q;
    assign overflow  = overflow_q;

`ifdef OVERTURE_OUT_FIFO_STATS_EN
    logic [BYTE_COUNT_W-1:0] byte_count_q, byte_count_d;
    logic [DROP_COUNT_W-1:0] drop_count_q, drop_count_d;

    always_comb begin
        byte_count_d = byte_count_q;
        drop_count_d = drop_count_q;
        if (flush) begin
            byte_count_d = '0;
            drop_count_d = '0;
        end else begin
            if (push) byte_count_d = byte_count_q + BYTE_COUNT_W'(1);
            if (drop && (drop_count_q != '1)) drop_count_d = drop_count_q + DROP_COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            byte_count_q <= byte_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign byte_count = byte_count_q;
    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_overture_out_fifo.sv
// tb/tb_overture_out_fifo.sv - directed self-checking bench for overture_out_fifo

module tb_overture_out_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       arch_output_enable;
    logic [7:0] arch_output_value;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [4:0] level;
    logic       overflow;
`ifdef OVERTURE_OUT_FIFO_STATS_EN
    logic [15:0] byte_count;
    logic [7:0]  drop_count;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    overture_out_fifo #(
        .UUID  (0),
        .NAME  ("tb"),
        .DEPTH (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .arch_output_enable (arch_output_enable),
        .arch_output_value  (arch_output_value),
        .flush              (flush),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .level              (level),
        .overflow           (overflow)
`ifdef OVERTURE_OUT_FIFO_STATS_EN
        ,
        .byte_count         (byte_count),
        .drop_count         (drop_count)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        arch_output_enable = 1'b0;
        arch_output_value  = 8'h00;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick;
        tick;
        chk("reset_level", level, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_overflow", overflow, 0);
        rst = 1'b1;
        tick;

        // Three pushes, then drain in consecutive cycles
        arch_output_enable = 1'b1;
        arch_output_value = 8'h41; tick;
        arch_output_value = 8'h42; tick;
        arch_output_value = 8'h43; tick;
        arch_output_enable = 1'b0;
        chk("abc_level", level, 3);
        chk("abc_valid", out_valid, 1);
        chk("abc_head", out_data, 8'h41);
        tick;
        chk("abc_hold", out_data, 8'h41);
        out_ready = 1'b1;
        chk("abc_d0", out_data, 8'h41); tick;
        chk("abc_d1", out_data, 8'h42); tick;
        chk("abc_d2", out_data, 8'h43); tick;
        chk("abc_empty_level", level, 0);
        chk("abc_empty_valid", out_valid, 0);
        out_ready = 1'b0;

        // Fill to full, then an extra byte is dropped
        arch_output_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            arch_output_value = 8'(i);
            tick;
        end
        chk("full_level", level, 16);
        chk("full_no_ovf", overflow, 0);
        arch_output_value = 8'hFF;
        tick;
        arch_output_enable = 1'b0;
        chk("drop_level", level, 16);
        chk("drop_ovf", overflow, 1);
`ifdef OVERTURE_OUT_FIFO_STATS_EN
        chk("drop_count", drop_count, 1);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_full_%0d", i), out_data, 8'(i));
            tick;
        end
        out_ready = 1'b0;
        chk("drain_full_empty", out_valid, 0);
        chk("ovf_sticky", overflow, 1);
        flush = 1'b1; tick; flush = 1'b0;
        chk("flush_clears_ovf", overflow, 0);

        // Push and pop together at full
        arch_output_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            arch_output_value = 8'(i);
            tick;
        end
        arch_output_value = 8'hAA;
        out_ready = 1'b1;
        chk("pp_full_head", out_data, 8'h00);
        tick;
        arch_output_enable = 1'b0;
        chk("pp_full_level", level, 16);
        chk("pp_full_ovf", overflow, 0);
        chk("pp_full_next", out_data, 8'h01);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("pp_drain_%0d", i), out_data, 8'(i));
            tick;
        end
        chk("pp_drain_last", out_data, 8'hAA);
        tick;
        chk("pp_drain_empty", level, 0);

        // Push with out_ready at empty: no pop that cycle
        arch_output_enable = 1'b1;
        arch_output_value = 8'h55;
        chk("pp_empty_valid_pre", out_valid, 0);
        tick;
        arch_output_enable = 1'b0;
        chk("pp_empty_valid", out_valid, 1);
        chk("pp_empty_data", out_data, 8'h55);
        chk("pp_empty_level", level, 1);
        tick;
        out_ready = 1'b0;
        chk("pp_empty_drained", level, 0);

        // Flush at level 5 with overflow set, push ignored
        arch_output_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            arch_output_value = 8'h30 + 8'(i);
            tick;
        end
        arch_output_value = 8'hEE;
        tick;
        arch_output_enable = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) tick;
        out_ready = 1'b0;
        chk("pre_flush_level", level, 5);
        chk("pre_flush_ovf", overflow, 1);
        chk("pre_flush_head", out_data, 8'h3B);
        flush = 1'b1;
        arch_output_enable = 1'b1;
        arch_output_value = 8'h77;
        tick;
        flush = 1'b0;
        arch_output_enable = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_ovf", overflow, 0);
        chk("flush_valid", out_valid, 0);
        arch_output_enable = 1'b1;
        arch_output_value = 8'h88;
        tick;
        arch_output_enable = 1'b0;
        chk("post_flush_level", level, 1);
        chk("post_flush_head", out_data, 8'h88);
        flush = 1'b1; tick; flush = 1'b0;

        // Asynchronous reset at level 7 mid-drain
        arch_output_enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            arch_output_value = 8'h60 + 8'(i);
            tick;
        end
        arch_output_enable = 1'b0;
        out_ready = 1'b1;
        tick; tick; tick;
        chk("mid_level", level, 7);
        chk("mid_head", out_data, 8'h63);
        rst = 1'b0;
        #2;
        chk("async_rst_level", level, 0);
        chk("async_rst_valid", out_valid, 0);
        tick;
        rst = 1'b1;
        out_ready = 1'b0;
        tick;
        arch_output_enable = 1'b1;
        arch_output_value = 8'h10;
        tick;
        arch_output_enable = 1'b0;
        chk("after_rst_head", out_data, 8'h10);
        chk("after_rst_level", level, 1);
`ifdef OVERTURE_OUT_FIFO_STATS_EN
        chk("after_rst_byte_count", byte_count, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
